// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM receive path.
package tdm_pkg;

  // Lock FSM: HUNT waits for a frame marker, LOCKED routes bits to slots.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NCH_DEF      = 4;
  localparam int MISS_MAX_DEF = 2;

endpackage

// File: rtl/tdm_demux4_if.sv
// Bundle of serial input, frame output handshake and status lines.
//
// Handshake: a frame transfers on every rising clk edge where
// frame_valid=1 and frame_ready=1. frame_data is held stable while
// frame_valid=1 and frame_ready=0; frame_valid never drops without a
// transfer except on reset.
interface tdm_demux4_if
  import tdm_pkg::*;
#(
  parameter int NCH = NCH_DEF
);
  localparam int SLOT_W = $clog2(NCH);

  logic              ena;
  logic              din;
  logic              sync;
  logic              frame_ready;
  logic [NCH-1:0]    frame_data;
  logic              frame_valid;
  logic              locked;
  logic [SLOT_W-1:0] slot_idx;
  logic              sync_err;
  logic              overflow;
  state_t            dbg_state;

  // Source of serial bits and consumer of frames.
  modport master (
    output ena, din, sync, frame_ready,
    input  frame_data, frame_valid, locked, slot_idx, sync_err, overflow, dbg_state
  );

  // The demultiplexer itself.
  modport slave (
    input  ena, din, sync, frame_ready,
    output frame_data, frame_valid, locked, slot_idx, sync_err, overflow, dbg_state
  );

endinterface

// File: rtl/tdm_frame_hold.sv
// One-entry output register for completed frames with overflow pulse.
module tdm_frame_hold #(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [NCH-1:0] push_data,
  input  logic           ready,
  output logic           valid,
  output logic [NCH-1:0] data,
  output logic           overflow
);

  // Load when empty or draining this edge; otherwise drop the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      data     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (push) begin
        if (!valid || ready) begin
          data  <= push_data;
          valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// TDM receive demultiplexer: tracks slot position from the frame marker,
// assembles one parallel word per frame and hands it to the output register.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int MISS_MAX = MISS_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

  localparam int SLOT_W = $clog2(NCH);
  localparam int MISS_W = $clog2(MISS_MAX + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NCH - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

  state_t            state;
  logic              locked;
  logic [SLOT_W-1:0] slot_idx;
  logic [NCH-2:0]    shadow;
  logic [MISS_W-1:0] miss_cnt;
  logic              sync_err;
  logic              push;
  logic [NCH-1:0]    push_data;

  // The last slot bit goes straight into the output register, so the frame
  // is offered on the same edge that samples it.
  assign push      = bus.ena && (state == LOCKED) && !bus.sync && (slot_idx == LAST_SLOT);
  assign push_data = {bus.din, shadow};

  // Lock FSM with slot counter, miss counter and shadow register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      locked   <= 1'b0;
      slot_idx <= '0;
      shadow   <= '0;
      miss_cnt <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (bus.ena) begin
        case (state)
          HUNT: begin
            if (bus.sync) begin
              shadow[0] <= bus.din;
              slot_idx  <= SLOT_W'(1);
              miss_cnt  <= '0;
              state     <= LOCKED;
              locked    <= 1'b1;
            end
          end
          LOCKED: begin
            if (bus.sync) begin
              // Marker realigns the frame; mid-frame marker is an error and
              // the bits gathered so far are abandoned.
              if (slot_idx != '0) begin
                sync_err <= 1'b1;
              end else begin
                miss_cnt <= '0;
              end
              shadow[0] <= bus.din;
              slot_idx  <= SLOT_W'(1);
            end else if (slot_idx == '0) begin
              if (miss_cnt == MISS_LAST) begin
                state    <= HUNT;
                locked   <= 1'b0;
                slot_idx <= '0;
                miss_cnt <= '0;
              end else begin
                miss_cnt  <= miss_cnt + MISS_W'(1);
                shadow[0] <= bus.din;
                slot_idx  <= SLOT_W'(1);
              end
            end else begin
              if (slot_idx != LAST_SLOT) begin
                shadow[slot_idx] <= bus.din;
                slot_idx         <= slot_idx + SLOT_W'(1);
              end else begin
                slot_idx <= '0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  tdm_frame_hold #(.NCH(NCH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .ready     (bus.frame_ready),
    .valid     (bus.frame_valid),
    .data      (bus.frame_data),
    .overflow  (bus.overflow)
  );

  assign bus.locked    = locked;
  assign bus.slot_idx  = slot_idx;
  assign bus.sync_err  = sync_err;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 with a frame scoreboard.
module tb_tdm_demux4;
  import tdm_pkg::*;

  localparam int NCH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [NCH-1:0] exp_q[$];

  tdm_demux4_if #(.NCH(NCH)) bus ();

  tdm_demux4 #(.NCH(NCH), .MISS_MAX(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, sample just after the edge.
  task automatic drive(input logic e, input logic d, input logic s);
    bus.ena  = e;
    bus.din  = d;
    bus.sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_rand();
    drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Send one frame, slot 0 first; optionally records the word as expected.
  task automatic send_frame(input logic [NCH-1:0] w, input logic s0,
                            input logic rdy_last, input bit record);
    for (int i = 0; i < NCH; i++) begin
      if (i == NCH - 1) begin
        bus.frame_ready = rdy_last;
        if (record) exp_q.push_back(w);
      end
      drive(1'b1, w[i], (i == 0) ? s0 : 1'b0);
    end
    bus.frame_ready = 1'b0;
  endtask

  // Scoreboard: compare the held frame against the oldest expected word.
  task automatic pop_check(input string tag);
    logic [NCH-1:0] e;
    chk({tag, "_valid"}, bus.frame_valid, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, bus.frame_data, e);
    end
  endtask

  task automatic consume(input string tag);
    logic [NCH-1:0] held;
    held = bus.frame_data;
    bus.frame_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    bus.frame_ready = 1'b0;
    chk({tag, "_valid_cleared"}, bus.frame_valid, 0);
    chk({tag, "_data_kept"}, bus.frame_data, held);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.ena = 1'b0;
    bus.din = 1'b0;
    bus.sync = 1'b0;
    bus.frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", bus.frame_data, 0);
    chk("rst_valid", bus.frame_valid, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_slot", bus.slot_idx, 0);
    chk("rst_sync_err", bus.sync_err, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_state", bus.dbg_state, HUNT);
    rst = 1'b0;

    // 1: basic frame 4'b1101
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("t1_hunt_ignore", bus.locked, 0);
    drive(1'b1, 1'b1, 1'b1);
    chk("t1_locked", bus.locked, 1);
    chk("t1_state", bus.dbg_state, LOCKED);
    chk("t1_slot1", bus.slot_idx, 1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("t1_no_valid_early", bus.frame_valid, 0);
    exp_q.push_back(4'b1101);
    drive(1'b1, 1'b1, 1'b0);
    pop_check("t1");
    chk("t1_slot_wrap", bus.slot_idx, 0);
    consume("t1");

    // 2: same frame with enable gaps
    drive(1'b1, 1'b1, 1'b1);
    repeat (3) idle_rand();
    chk("t2_slot_hold1", bus.slot_idx, 1);
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) idle_rand();
    chk("t2_slot_hold2", bus.slot_idx, 2);
    drive(1'b1, 1'b1, 1'b0);
    repeat (3) idle_rand();
    chk("t2_slot_hold3", bus.slot_idx, 3);
    chk("t2_no_valid_early", bus.frame_valid, 0);
    exp_q.push_back(4'b1101);
    drive(1'b1, 1'b1, 1'b0);
    pop_check("t2");
    consume("t2");

    // 3: sync at slot 2 realigns
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    chk("t3_slot2", bus.slot_idx, 2);
    drive(1'b1, 1'b1, 1'b1);
    chk("t3_sync_err", bus.sync_err, 1);
    chk("t3_slot_realign", bus.slot_idx, 1);
    chk("t3_partial_dropped", bus.frame_valid, 0);
    drive(1'b1, 1'b0, 1'b0);
    chk("t3_sync_err_pulse", bus.sync_err, 0);
    drive(1'b1, 1'b1, 1'b0);
    chk("t3_no_valid_early", bus.frame_valid, 0);
    exp_q.push_back(4'b0101);
    drive(1'b1, 1'b0, 1'b0);
    pop_check("t3");
    consume("t3");

    // 4: overflow, then simultaneous consume and load
    send_frame(4'hA, 1'b1, 1'b0, 1'b1);
    chk("t4_a_valid", bus.frame_valid, 1);
    send_frame(4'h5, 1'b1, 1'b0, 1'b0);
    chk("t4_overflow", bus.overflow, 1);
    pop_check("t4_held_a");
    drive(1'b0, 1'b0, 1'b0);
    chk("t4_overflow_pulse", bus.overflow, 0);
    send_frame(4'h5, 1'b1, 1'b1, 1'b1);
    chk("t4_no_overflow", bus.overflow, 0);
    pop_check("t4_swap");
    consume("t4");

    // 5: lost sync drops lock on the second missing marker
    send_frame(4'h6, 1'b0, 1'b0, 1'b1);
    chk("t5_still_locked", bus.locked, 1);
    pop_check("t5_freewheel");
    consume("t5");
    drive(1'b1, 1'b1, 1'b0);
    chk("t5_unlocked", bus.locked, 0);
    chk("t5_slot0", bus.slot_idx, 0);
    chk("t5_state", bus.dbg_state, HUNT);
    drive(1'b1, 1'b1, 1'b0);
    chk("t5_hunt_slot", bus.slot_idx, 0);
    send_frame(4'h3, 1'b1, 1'b0, 1'b1);
    chk("t5_relocked", bus.locked, 1);
    pop_check("t5_relock");
    consume("t5b");

    // 6: asynchronous reset mid-frame
    send_frame(4'h9, 1'b1, 1'b0, 1'b1);
    pop_check("t6_pre");
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    chk("t6_slot2", bus.slot_idx, 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus.frame_valid, 0);
    chk("t6_rst_data", bus.frame_data, 0);
    chk("t6_rst_locked", bus.locked, 0);
    chk("t6_rst_slot", bus.slot_idx, 0);
    chk("t6_rst_sync_err", bus.sync_err, 0);
    chk("t6_rst_overflow", bus.overflow, 0);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    send_frame(4'hC, 1'b1, 1'b0, 1'b1);
    chk("t6_sync_err_clean", bus.sync_err, 0);
    pop_check("t6_clean");
    consume("t6");

    chk("sb_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
